// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, interrupt FSM states and PC helper
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] INT_VECTOR_DEF = 32'h0000_0100;
  localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ISR  = 2'd2
  } int_state_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory bus and IF/ID register bundle
interface fetch_stage_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] curr_pc;
  logic [31:0] next_pc;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output instruction,
    output curr_pc,
    output next_pc
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  instruction,
    input  curr_pc,
    input  next_pc
  );

endinterface

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt pending latch, entry FSM, EPC and acknowledge pulse
module int_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_mem,
  input  logic        rti_ex,
  input  logic        branch_taken,
  input  logic        int_req,
  input  logic        interrupt_branch_alert,
  input  logic [31:0] pc,
  output logic        entry,
  output logic [31:0] epc,
  output logic        int_ack,
  output logic        in_isr
);

  int_state_t state;
  logic       pending;

  // Entry must not collide with a redirect or a stall, nor split a branch in decode.
  assign entry  = (state == ST_PEND) && !interrupt_branch_alert &&
                  !branch_taken && !rti_ex && !stall_mem;
  assign in_isr = (state == ST_ISR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      epc     <= 32'h0;
      int_ack <= 1'b0;
    end else begin
      int_ack <= entry;
      // A request arriving in the entry cycle is absorbed by that entry.
      if (entry) begin
        pending <= 1'b0;
      end else if (int_req) begin
        pending <= 1'b1;
      end

      if (entry) begin
        epc   <= pc;
        state <= ST_ISR;
      end else if (!stall_mem) begin
        case (state)
          ST_IDLE: if (pending) state <= ST_PEND;
          ST_ISR:  if (rti_ex) state <= pending ? ST_PEND : ST_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, redirect priority and IF/ID pipeline register
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] INT_VECTOR = INT_VECTOR_DEF,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hazard,
  input  logic                 stall_mem,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 rti_ex,
  input  logic                 int_req,
  input  logic                 interrupt_branch_alert,
  fetch_stage_if.master        bus,
  output logic                 int_ack,
  output logic                 in_isr
);

  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] curr_pc_q;
  logic [31:0] next_pc_q;
  logic [31:0] epc;
  logic        entry;

  int_ctrl u_int_ctrl (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .stall_mem              (stall_mem),
    .rti_ex                 (rti_ex),
    .branch_taken           (branch_taken),
    .int_req                (int_req),
    .interrupt_branch_alert (interrupt_branch_alert),
    .pc                     (pc),
    .entry                  (entry),
    .epc                    (epc),
    .int_ack                (int_ack),
    .in_isr                 (in_isr)
  );

  assign bus.imem_addr   = pc;
  assign bus.instruction = instr_q;
  assign bus.curr_pc     = curr_pc_q;
  assign bus.next_pc     = next_pc_q;

  // Redirect priority: memory stall, return, branch, interrupt entry, load-use hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      instr_q   <= NOP_INSTR;
      curr_pc_q <= 32'h0;
      next_pc_q <= 32'h0;
    end else if (stall_mem) begin
      pc <= pc;
    end else if (rti_ex || branch_taken || entry) begin
      if (rti_ex) begin
        pc <= epc;
      end else if (branch_taken) begin
        pc <= branch_target;
      end else begin
        pc <= INT_VECTOR;
      end
      instr_q   <= NOP_INSTR;
      curr_pc_q <= 32'h0;
      next_pc_q <= 32'h0;
    end else if (!hazard) begin
      pc        <= pc_plus4(pc);
      instr_q   <= bus.imem_rdata;
      curr_pc_q <= pc;
      next_pc_q <= pc_plus4(pc);
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded at reset.
REQ-002 Parameter INT_VECTOR, default 32'h0000_0100, interrupt service entry address.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 hazard  input  1  load-use stall from decode: hold PC and IF/ID.
REQ-007 stall_mem  input  1  memory stall: hold all state.
REQ-008 branch_taken  input  1  taken branch/jump resolved in EX this cycle.
REQ-009 branch_target  input  32  redirect address, valid with branch_taken.
REQ-010 rti_ex  input  1  return-from-interrupt resolved in EX this cycle.
REQ-011 int_req  input  1  external interrupt request pulse.
REQ-012 interrupt_branch_alert  input  1  decode holds a branch/jal/jalr; interrupt entry blocked.
REQ-013 imem_addr  output  32  instruction memory address, equals PC register.
REQ-014 imem_rdata  input  32  instruction word, combinational from imem_addr same cycle.
REQ-015 instruction  output  32  IF/ID instruction register.
REQ-016 curr_pc  output  32  IF/ID address of instruction.
REQ-017 next_pc  output  32  IF/ID curr_pc+4.
REQ-018 int_ack  output  1  one-cycle pulse on interrupt entry.
REQ-019 in_isr  output  1  high while servicing an interrupt.

Function
REQ-020 Per-cycle priority: reset > stall_mem > rti_ex > branch_taken > interrupt entry > hazard > sequential fetch.
REQ-021 stall_mem: PC, IF/ID, EPC, FSM, pending latch all hold; int_req still sets pending.
REQ-022 Sequential: PC <= PC+4 (mod 2^32, wraps to 0); IF/ID <= {imem_rdata, PC, PC+4}; latency one cycle address-to-instruction.
REQ-023 hazard (no redirect): PC and IF/ID hold.
REQ-024 branch_taken: PC <= branch_target; IF/ID <= {NOP_INSTR, 0, 0}; hazard ignored that cycle.
REQ-025 rti_ex: PC <= EPC; IF/ID <= bubble; in_isr cleared; wins over simultaneous branch_taken.
REQ-026 int_req sets pending latch in any state; pending cleared only on entry.
REQ-027 FSM states IDLE, PEND, ISR; IDLE->PEND when pending set.
REQ-028 PEND->ISR (entry) when not interrupt_branch_alert, not branch_taken, not rti_ex, not stall_mem: EPC <= PC; PC <= INT_VECTOR; IF/ID <= bubble; int_ack=1; pending cleared.
REQ-029 Entry overrides hazard (instruction in decode still completes; PC refetch from EPC).
REQ-030 ISR: further int_req latch pending, no nesting; ISR->PEND on rti_ex if pending, else ISR->IDLE.
REQ-031 int_req in same cycle as entry is absorbed into that entry.
REQ-032 in_isr = (state==ISR); imem_addr = PC combinationally.

Reset
REQ-033 On rst_n low at posedge: PC=RESET_PC, instruction=NOP_INSTR, curr_pc=0, next_pc=0, EPC=0, pending=0, state=IDLE, int_ack=0.
REQ-034 Reset mid-ISR or mid-stall discards all state including pending interrupt.

Structure
REQ-035 NOP_INSTR, RESET_PC, INT_VECTOR defaults and FSM state enum reside in shared package cpu_pkg.
REQ-036 One sub-module natural: int_ctrl (pending latch, FSM, EPC, int_ack); PC/IF-ID in top.

Verification
REQ-037 Reset then 4 free cycles, imem word = addr -> curr_pc 0,4,8; instruction 0,4,8; next_pc 4,8,12.
REQ-038 branch_taken with target 0x40 at PC=0x10 -> next cycle instruction=0x13, PC=0x40; following cycle curr_pc=0x40.
REQ-039 hazard 2 cycles at PC=0x8 -> IF/ID holds curr_pc=0x4 both cycles, PC stays 0x8; stall_mem with int_req -> nothing moves, entry after release.
REQ-040 int_req at PC=0x20 with interrupt_branch_alert high 2 cycles -> no int_ack until alert low; then EPC=PC, PC=0x100, int_ack one cycle, in_isr=1.
REQ-041 rti_ex in ISR with EPC=0x24 -> PC=0x24, bubble, in_isr=0; int_req during ISR -> re-entry immediately after return.
REQ-042 PC=0xFFFF_FFFC sequential -> PC wraps to 0; rst_n low mid-ISR -> all REQ-033 values.
